// File: rtl/axi_rd_burst_checker.sv
// AXI4 read-data burst checker: compares each returned beat against the
// {zero, 16'hCAFE, addr[7:0]} write pattern and reports per-burst status plus
// a sticky compare-error flag.
module axi_rd_burst_checker #(
   parameter int unsigned          DATA_WIDTH = 128,
   parameter int unsigned          ID_WIDTH   = 2,
   parameter logic [ID_WIDTH-1:0]  EXP_ID     = 2'b01,
   parameter int unsigned          TIMEOUT    = 1024
) (
   input  logic                  ui_clk,
   input  logic                  aresetn,
   input  logic                  start,
   input  logic [7:0]            start_len,
   input  logic [7:0]            start_base,
   input  logic [ID_WIDTH-1:0]   s_axi_rid,
   input  logic [DATA_WIDTH-1:0] s_axi_rdata,
   input  logic [1:0]            s_axi_rresp,
   input  logic                  s_axi_rlast,
   input  logic                  s_axi_rvalid,
   output logic                  s_axi_rready,
   output logic                  busy,
   output logic                  done,
   output logic [4:0]            err_flags,
   output logic [15:0]           err_count,
   output logic [7:0]            first_err_beat,
   output logic                  tg_compare_error
);

   localparam int unsigned IDLE_CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e                  r_state;
   state_e                  w_state_next;
   logic [7:0]              r_len;
   logic [7:0]              r_base;
   logic [7:0]              r_beat;
   logic [IDLE_CNT_W-1:0]   r_idle;
   logic [4:0]              r_flags;
   logic [15:0]             r_cnt;
   logic [7:0]              r_first;
   logic                    r_tg;

   logic                    w_busy;
   logic                    w_hs;
   logic                    w_run_hs;
   logic                    w_start_acc;
   logic                    w_timeout;
   logic                    w_at_len;
   logic [7:0]              w_exp_byte;
   logic [DATA_WIDTH-1:0]   w_exp;
   logic                    w_data_bad;
   logic [4:0]              w_flag_set;

   assign w_busy      = (r_state == StRun) || (r_state == StDrain);
   assign w_hs        = s_axi_rvalid & w_busy;
   assign w_run_hs    = w_hs && (r_state == StRun);
   assign w_start_acc = (r_state == StIdle) && start;
   assign w_at_len    = (r_beat == r_len);
   // Fires on the last of TIMEOUT consecutive beat-less cycles.
   assign w_timeout   = w_busy && !w_hs && (r_idle == IDLE_CNT_W'(TIMEOUT - 1));
   assign w_exp_byte  = r_base + r_beat;

   // Expected beat data: everything above the 24-bit pattern must be zero.
   always_comb begin
      w_exp       = '0;
      w_exp[23:0] = {16'hCAFE, w_exp_byte};
   end

   assign w_data_bad = (s_axi_rdata != w_exp);

   // Error bits raised this cycle: {timeout, last, id, resp, data}.
   always_comb begin
      w_flag_set = '0;
      if (w_run_hs) begin
         w_flag_set[0] = w_data_bad;
         w_flag_set[1] = (s_axi_rresp != 2'b00);
         w_flag_set[2] = (s_axi_rid != EXP_ID);
         w_flag_set[3] = s_axi_rlast ^ w_at_len;
      end
      if (w_timeout) begin
         w_flag_set[4] = 1'b1;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (start) w_state_next = StRun;
         end
         StRun: begin
            if (w_hs) begin
               if (s_axi_rlast)   w_state_next = StDone;
               else if (w_at_len) w_state_next = StDrain;
            end else if (w_timeout) begin
               w_state_next = StDone;
            end
         end
         StDrain: begin
            if (w_hs && s_axi_rlast) w_state_next = StDone;
            else if (w_timeout)      w_state_next = StDone;
         end
         StDone: begin
            w_state_next = StIdle;
         end
         default: w_state_next = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge ui_clk) begin
      if (!aresetn) r_state <= StIdle;
      else          r_state <= w_state_next;
   end

   // Burst context, idle counter and error bookkeeping.
   always_ff @(posedge ui_clk) begin
      if (!aresetn) begin
         r_len   <= '0;
         r_base  <= '0;
         r_beat  <= '0;
         r_idle  <= '0;
         r_flags <= '0;
         r_cnt   <= '0;
         r_first <= 8'hFF;
         r_tg    <= 1'b0;
      end else begin
         // Sticky flag lags the per-burst flags by one cycle.
         r_tg <= r_tg | (|r_flags);
         if (w_start_acc) begin
            r_len   <= start_len;
            r_base  <= start_base;
            r_beat  <= '0;
            r_idle  <= '0;
            r_flags <= '0;
            r_cnt   <= '0;
            r_first <= 8'hFF;
         end else begin
            r_flags <= r_flags | w_flag_set;
            if (w_busy) begin
               r_idle <= w_hs ? '0 : r_idle + IDLE_CNT_W'(1);
            end
            if (w_run_hs) begin
               if (!s_axi_rlast && !w_at_len) r_beat <= r_beat + 8'd1;
               if (w_data_bad) begin
                  if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
                  if (r_first == 8'hFF)  r_first <= r_beat;
               end
            end
         end
      end
   end

   assign s_axi_rready     = w_busy;
   assign busy             = w_busy;
   assign done             = (r_state == StDone);
   assign err_flags        = r_flags;
   assign err_count        = r_cnt;
   assign first_err_beat   = r_first;
   assign tg_compare_error = r_tg;

endmodule

// File: tb/tb_axi_rd_burst_checker.sv
// Bench for axi_rd_burst_checker: directed and randomised bursts checked
// against a reference model computed from the burst description.
module tb_axi_rd_burst_checker;

   localparam int unsigned DW = 128;
   localparam int unsigned IW = 2;
   localparam int unsigned TO = 64;
   localparam logic [IW-1:0] EXP_ID = 2'b01;

   logic          ui_clk;
   logic          aresetn;
   logic          start;
   logic [7:0]    start_len;
   logic [7:0]    start_base;
   logic [IW-1:0] s_axi_rid;
   logic [DW-1:0] s_axi_rdata;
   logic [1:0]    s_axi_rresp;
   logic          s_axi_rlast;
   logic          s_axi_rvalid;
   logic          s_axi_rready;
   logic          busy;
   logic          done;
   logic [4:0]    err_flags;
   logic [15:0]   err_count;
   logic [7:0]    first_err_beat;
   logic          tg_compare_error;

   int n_chk = 0;
   int n_err = 0;
   bit tg_model = 1'b0;

   axi_rd_burst_checker #(
      .DATA_WIDTH (DW),
      .ID_WIDTH   (IW),
      .EXP_ID     (EXP_ID),
      .TIMEOUT    (TO)
   ) u_dut (
      .ui_clk           (ui_clk),
      .aresetn          (aresetn),
      .start            (start),
      .start_len        (start_len),
      .start_base       (start_base),
      .s_axi_rid        (s_axi_rid),
      .s_axi_rdata      (s_axi_rdata),
      .s_axi_rresp      (s_axi_rresp),
      .s_axi_rlast      (s_axi_rlast),
      .s_axi_rvalid     (s_axi_rvalid),
      .s_axi_rready     (s_axi_rready),
      .busy             (busy),
      .done             (done),
      .err_flags        (err_flags),
      .err_count        (err_count),
      .first_err_beat   (first_err_beat),
      .tg_compare_error (tg_compare_error)
   );

   initial ui_clk = 1'b0;
   always #5 ui_clk = ~ui_clk;

   // Hard stop in case something stalls far beyond any expected run length.
   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [127:0] pat(input logic [7:0] base, input int i);
      logic [7:0] b;
      b = base + 8'(i);
      return {104'b0, 16'hCAFE, b};
   endfunction

   task automatic idle_inputs();
      start        = 1'b0;
      s_axi_rvalid = 1'b0;
      s_axi_rlast  = 1'b0;
      s_axi_rresp  = 2'b00;
      s_axi_rid    = EXP_ID;
      s_axi_rdata  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic check_reset_values(input string name);
      check({name, "/rready"}, s_axi_rready, 1'b0);
      check({name, "/busy"}, busy, 1'b0);
      check({name, "/done"}, done, 1'b0);
      check({name, "/flags"}, err_flags, 5'b0);
      check({name, "/count"}, err_count, 16'h0);
      check({name, "/first"}, first_err_beat, 8'hFF);
      check({name, "/tg"}, tg_compare_error, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge ui_clk);
      aresetn = 1'b0;
      idle_inputs();
      @(negedge ui_clk);
      aresetn = 1'b1;
      tg_model = 1'b0;
   endtask

   // One burst: beats 0..rlast_pos are offered (rlast only on rlast_pos), unless
   // stall_at stops delivery early (timeout) or reset_at pulses aresetn.
   task automatic run_burst(input string name, input int len, input logic [7:0] base,
                            input int rlast_pos, input int cor_a, input int cor_b,
                            input int bad_resp, input int bad_id, input bit gaps,
                            input bit poke_done, input int stall_at, input int reset_at);
      logic [4:0]   ef;
      int           ec;
      logic [7:0]   efirst;
      int           n_cmp;
      int           last_i;
      int           k;
      bit           aborted;
      logic [127:0] d;

      // Reference: compared beats are 0..min(first rlast, len), or those sent before a stall.
      ef      = '0;
      ec      = 0;
      efirst  = 8'hFF;
      aborted = 1'b0;
      n_cmp   = (stall_at >= 0) ? stall_at : ((rlast_pos < len) ? rlast_pos : len) + 1;
      for (int i = 0; i < n_cmp; i++) begin
         if (i == cor_a || i == cor_b) begin
            ef[0] = 1'b1;
            ec++;
            if (efirst == 8'hFF) efirst = 8'(i);
         end
         if (i == bad_resp) ef[1] = 1'b1;
         if (i == bad_id)   ef[2] = 1'b1;
      end
      ef[3] = (stall_at < 0) && (rlast_pos != len);
      ef[4] = (stall_at >= 0);

      @(negedge ui_clk);
      start      = 1'b1;
      start_len  = 8'(len);
      start_base = base;
      @(negedge ui_clk);
      start = 1'b0;
      check({name, "/rready_rise"}, s_axi_rready, 1'b1);

      last_i = (stall_at >= 0) ? stall_at - 1 : rlast_pos;
      for (int i = 0; i <= last_i; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               s_axi_rvalid = 1'b0;
               s_axi_rdata  = {$urandom, $urandom, $urandom, $urandom};
               @(negedge ui_clk);
            end
         end
         d = pat(base, i);
         if (i == cor_a) d[7:0] = d[7:0] ^ 8'h50;
         if (i == cor_b) d[24 + $urandom_range(0, 103)] = 1'b1;
         s_axi_rdata  = d;
         s_axi_rid    = (i == bad_id) ? ~EXP_ID : EXP_ID;
         s_axi_rresp  = (i == bad_resp) ? 2'($urandom_range(1, 3)) : 2'b00;
         s_axi_rlast  = (i == rlast_pos);
         s_axi_rvalid = 1'b1;
         if (i == reset_at) begin
            aresetn = 1'b0;
            @(negedge ui_clk);
            aresetn = 1'b1;
            idle_inputs();
            check_reset_values({name, "/mid_reset"});
            tg_model = 1'b0;
            return;
         end
         check({name, "/rready_beat"}, s_axi_rready, 1'b1);
         if (s_axi_rready !== 1'b1) begin
            aborted = 1'b1;
            break;
         end
         @(negedge ui_clk);
      end
      idle_inputs();

      if (aborted) begin
         do_reset();
         return;
      end

      if (stall_at >= 0) begin
         k = 1;
         while (done !== 1'b1 && k < int'(TO) + 10) begin
            @(negedge ui_clk);
            k++;
         end
         check({name, "/timeout_latency"}, (k >= int'(TO) && k <= int'(TO) + 2), 1'b1);
      end

      check({name, "/done"}, done, 1'b1);
      check({name, "/rready_fall"}, s_axi_rready, 1'b0);
      check({name, "/flags"}, err_flags, ef);
      check({name, "/count"}, err_count, 16'(ec));
      check({name, "/first"}, first_err_beat, efirst);

      if (poke_done) begin
         start      = 1'b1;
         start_len  = 8'd3;
         start_base = 8'($urandom);
      end
      @(negedge ui_clk);
      start = 1'b0;
      check({name, "/done_pulse"}, done, 1'b0);
      check({name, "/idle_after"}, busy, 1'b0);
      check({name, "/flags_held"}, err_flags, ef);
      tg_model = tg_model | (|ef);
      check({name, "/tg"}, tg_compare_error, tg_model);
   endtask

   initial begin
      int len;
      int rl;
      int ca;
      int cb;
      int br;
      int bi;

      aresetn    = 1'b0;
      start_len  = 8'd0;
      start_base = 8'd0;
      idle_inputs();
      repeat (3) @(negedge ui_clk);
      check_reset_values("reset");
      aresetn = 1'b1;

      //         name       len base   rlast ca  cb  resp id  gaps poke stall rst
      run_burst("clean16",   15, 8'h00, 15,   -1, -1, -1,  -1, 0,   0,   -1,   -1);
      run_burst("corrupt",   15, 8'h00, 15,    5,  9, -1,  -1, 0,   0,   -1,   -1);
      run_burst("sticky",    15, 8'h00, 15,   -1, -1, -1,  -1, 0,   1,   -1,   -1);
      run_burst("early_last",15, 8'h10,  3,   -1, -1, -1,  -1, 0,   0,   -1,   -1);
      run_burst("drain",     15, 8'h20, 17,   -1, -1, -1,  -1, 0,   0,   -1,   -1);
      run_burst("resp_id",    7, 8'h40,  7,   -1, -1,  2,   4, 1,   0,   -1,   -1);
      run_burst("timeout",   15, 8'h30, 15,   -1, -1, -1,  -1, 0,   0,    6,   -1);
      run_burst("wrap",      15, 8'hF8, 15,   -1, -1, -1,  -1, 0,   0,   -1,   -1);
      run_burst("rst_beat7", 15, 8'h55, 15,    2, -1, -1,  -1, 0,   0,   -1,    7);
      run_burst("post_rst",  15, 8'hA0, 15,   -1, -1, -1,  -1, 1,   0,   -1,   -1);
      run_burst("single",     0, 8'hFF,  0,    0, -1, -1,  -1, 0,   1,   -1,   -1);

      for (int n = 0; n < 16; n++) begin
         len = $urandom_range(0, 20);
         rl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len + 3) : len;
         ca  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1;
         cb  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1;
         br  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
         bi  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
         run_burst("random", len, 8'($urandom), rl, ca, cb, br, bi, 1'b1,
                   1'($urandom_range(0, 1)), -1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
